rr_arb8: RTL and testbench

Eight-way round-robin arbiter that shares one resource among eight requesters and drives the resource's select lines as a registered one-hot grant plus a 3-bit encoded index. It sits between the requesting blocks and the shared datapath, replacing a free-running one-hot decode of an address with a fair, sequenced selection. The grant holds until its owner releases it; an optional hold limit forces rotation.

---
 rtl/rr_arb8.sv | 132 +++++++++++++
 tb/tb_rr_arb8.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_arb8.sv
// rr_arb8: eight-way round-robin arbiter with a registered one-hot grant and an encoded index.
// Define RR_ARB8_TIMEOUT_EN to force rotation after HOLD_MAX contested cycles.
module rr_arb8 #(
    parameter int unsigned HOLD_MAX = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] req,
    output logic [7:0] gnt,
    output logic       gnt_valid,
    output logic [2:0] gnt_idx
);

    localparam int unsigned N  = 8;
    localparam int unsigned IW = 3;
    localparam int unsigned CW = 8;

    if (HOLD_MAX < 1 || HOLD_MAX > 255) begin : g_bad_hold_max
        $error("rr_arb8: HOLD_MAX out of range 1..255");
    end

    typedef enum logic {IDLE, BUSY} state_t;

    state_t        state, state_nx;
    logic [IW-1:0] ptr, ptr_nx;
    logic [N-1:0]  gnt_nx;
    logic [IW-1:0] idx_nx;
    logic          valid_nx;

    logic [N-1:0]  cand;
    logic          cand_any;
    logic [IW-1:0] win;
    logic          forced;

`ifdef RR_ARB8_TIMEOUT_EN
    localparam logic [CW-1:0] HOLD_LIM  = CW'(HOLD_MAX);
    localparam logic [CW-1:0] HOLD_LAST = CW'(HOLD_MAX - 1);

    logic [CW-1:0] hold_cnt, hold_nx;

    // Owner has been visible for HOLD_MAX cycles by this edge and someone else is waiting.
    assign forced = (hold_cnt >= HOLD_LAST) && cand_any;
`else
    assign forced = 1'b0;
`endif

    // First pending non-owner request at or after ptr, wrapping modulo 8.
    always_comb begin
        logic [IW-1:0] probe;
        cand     = req & ~gnt;
        cand_any = |cand;
        win      = ptr;
        probe    = ptr;
        for (int i = N - 1; i >= 0; i--) begin
            probe = ptr + IW'(i);
            if (cand[probe]) begin
                win = probe;
            end
        end
    end

    always_comb begin
        logic take;
        take     = 1'b0;
        state_nx = state;
        ptr_nx   = ptr;
        gnt_nx   = gnt;
        idx_nx   = gnt_idx;
        valid_nx = gnt_valid;
`ifdef RR_ARB8_TIMEOUT_EN
        hold_nx  = hold_cnt;
`endif
        case (state)
            IDLE: begin
                take = cand_any;
            end
            BUSY: begin
                if (!req[gnt_idx] || forced) begin
                    if (cand_any) begin
                        take = 1'b1;
                    end else begin
                        state_nx = IDLE;
                        gnt_nx   = '0;
                        valid_nx = 1'b0;
                    end
                end else begin
`ifdef RR_ARB8_TIMEOUT_EN
                    if (hold_cnt < HOLD_LIM) begin
                        hold_nx = hold_cnt + CW'(1);
                    end
`endif
                end
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
        if (take) begin
            state_nx = BUSY;
            gnt_nx   = N'(1) << win;
            idx_nx   = win;
            valid_nx = 1'b1;
            ptr_nx   = win + IW'(1);
`ifdef RR_ARB8_TIMEOUT_EN
            hold_nx  = '0;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            ptr       <= '0;
            gnt       <= '0;
            gnt_idx   <= '0;
            gnt_valid <= 1'b0;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_cnt  <= '0;
`endif
        end else begin
            state     <= state_nx;
            ptr       <= ptr_nx;
            gnt       <= gnt_nx;
            gnt_idx   <= idx_nx;
            gnt_valid <= valid_nx;
`ifdef RR_ARB8_TIMEOUT_EN
            hold_cnt  <= hold_nx;
`endif
        end
    end

endmodule

// File: tb/tb_rr_arb8.sv
// tb_rr_arb8: directed and randomized checks of rr_arb8 against a behavioural round-robin model.
module tb_rr_arb8;

    localparam int HOLD = 4;

    logic       clk;
    logic       rst_n;
    logic [7:0] req;
    logic [7:0] gnt;
    logic       gnt_valid;
    logic [2:0] gnt_idx;

    int total = 0;
    int bad   = 0;

    // Reference model state: who owns the grant, where the search starts, cycles held.
    bit m_busy;
    int m_owner;
    int m_ptr;
    int m_held;

    rr_arb8 #(.HOLD_MAX(HOLD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .gnt      (gnt),
        .gnt_valid(gnt_valid),
        .gnt_idx  (gnt_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int pick(input logic [7:0] r, input int start);
        for (int i = 0; i < 8; i++) begin
            if (r[(start + i) % 8]) return (start + i) % 8;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_busy  = 1'b0;
        m_owner = 0;
        m_ptr   = 0;
        m_held  = 0;
    endtask

    task automatic model_grant(input int w);
        m_owner = w;
        m_busy  = 1'b1;
        m_ptr   = (w + 1) % 8;
        m_held  = 1;
    endtask

    task automatic model_edge(input logic [7:0] r);
        int         w;
        bit         rel;
        logic [7:0] oth;
        if (!m_busy) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
        end else begin
            oth = r & ~(8'd1 << m_owner);
            rel = !r[m_owner];
`ifdef RR_ARB8_TIMEOUT_EN
            if (m_held >= HOLD && oth != 8'd0) rel = 1'b1;
`endif
            if (rel) begin
                w = pick(oth, m_ptr);
                if (w >= 0) model_grant(w);
                else m_busy = 1'b0;
            end else begin
                m_held++;
            end
        end
    endtask

    task automatic check_model(input string tag);
        logic [7:0] eg;
        logic [2:0] ei;
        eg = m_busy ? (8'd1 << m_owner) : 8'd0;
        ei = 3'(m_owner);
        total++;
        assert (gnt === eg) else begin
            bad++;
            $error("FAIL %s gnt got=%h exp=%h", tag, gnt, eg);
        end
        total++;
        assert (gnt_valid === m_busy) else begin
            bad++;
            $error("FAIL %s gnt_valid got=%b exp=%b", tag, gnt_valid, m_busy);
        end
        total++;
        assert (gnt_idx === ei) else begin
            bad++;
            $error("FAIL %s gnt_idx got=%0d exp=%0d", tag, gnt_idx, ei);
        end
    endtask

    task automatic expect_out(input string tag, input logic [7:0] eg, input logic ev,
                              input logic [2:0] ei);
        total++;
        assert (gnt === eg && gnt_valid === ev && gnt_idx === ei) else begin
            bad++;
            $error("FAIL %s got gnt=%h v=%b idx=%0d exp gnt=%h v=%b idx=%0d",
                   tag, gnt, gnt_valid, gnt_idx, eg, ev, ei);
        end
    endtask

    // Drive req on the falling edge, advance model at the rising edge, sample 1ns later.
    task automatic step(input logic [7:0] r, input string tag);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_edge(r);
        #1;
        check_model(tag);
    endtask

    task automatic do_reset(input string tag);
        @(negedge clk);
        rst_n = 1'b0;
        req   = 8'd0;
        #1;
        model_reset();
        expect_out(tag, 8'h00, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        logic [7:0] r;
        rst_n = 1'b0;
        req   = 8'd0;
        model_reset();
        #12;
        expect_out("reset_initial", 8'h00, 1'b0, 3'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Single request and release; index is retained while idle.
        step(8'h20, "single_grant");
        expect_out("single_grant_d", 8'h20, 1'b1, 3'd5);
        step(8'h00, "single_release");
        expect_out("single_release_d", 8'h00, 1'b0, 3'd5);

        // Zero-gap handoff and wrap-around from 7 back to 2.
        do_reset("reset_before_wrap");
        step(8'h84, "wrap_first");
        expect_out("wrap_first_d", 8'h04, 1'b1, 3'd2);
        step(8'h80, "wrap_handoff");
        expect_out("wrap_handoff_d", 8'h80, 1'b1, 3'd7);
        step(8'h84, "wrap_hold");
        expect_out("wrap_hold_d", 8'h80, 1'b1, 3'd7);
        step(8'h04, "wrap_back");
        expect_out("wrap_back_d", 8'h04, 1'b1, 3'd2);
        step(8'h00, "wrap_idle");

        // Asynchronous reset in the middle of a grant.
        do_reset("reset_before_mid");
        step(8'h04, "mid_grant");
        expect_out("mid_grant_d", 8'h04, 1'b1, 3'd2);
        do_reset("reset_mid_grant");
        step(8'h01, "after_reset");
        expect_out("after_reset_d", 8'h01, 1'b1, 3'd0);
        step(8'h00, "after_reset_idle");

        // Fairness: all request, each owner drops its bit after holding.
        do_reset("reset_before_fair");
        step(8'hFF, "fair_start");
        for (int g = 0; g < 9; g++) begin
            expect_out("fair_order", 8'd1 << (g % 8), 1'b1, 3'(g % 8));
            step(8'hFF, "fair_hold1");
            step(8'hFF, "fair_hold2");
            step(8'hFF & ~(8'd1 << (g % 8)), "fair_drop");
        end
        step(8'h00, "fair_idle");

        // Two constant contenders: rotate every HOLD cycles only when the timeout exists.
        do_reset("reset_before_timeout");
        for (int i = 0; i < 20; i++) begin
            step(8'h03, "timeout_model");
`ifdef RR_ARB8_TIMEOUT_EN
            expect_out("timeout_alt", ((i / HOLD) % 2) != 0 ? 8'h02 : 8'h01, 1'b1,
                       ((i / HOLD) % 2) != 0 ? 3'd1 : 3'd0);
`else
            expect_out("no_timeout_hold", 8'h01, 1'b1, 3'd0);
`endif
        end

        // A sole requester is never forced off.
        do_reset("reset_before_sole");
        for (int i = 0; i < 20; i++) begin
            step(8'h10, "sole_model");
            expect_out("sole_hold", 8'h10, 1'b1, 3'd4);
        end
        step(8'h00, "sole_idle");

        // Randomized request patterns held for random stretches.
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 3))
                0:       r = 8'($urandom);
                1:       r = 8'($urandom) & 8'($urandom);
                2:       r = 8'd1 << $urandom_range(0, 7);
                default: r = 8'($urandom) | 8'($urandom);
            endcase
            repeat ($urandom_range(1, 6)) step(r, "random");
            if ($urandom_range(0, 40) == 0) do_reset("random_reset");
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
